// File: rtl/f1_reaction_timer.sv
// Reaction timer fed by the F1 start-light bus: arms on a light sequence, times lights-out to button press in ms.
// Optional BCD result output when F1_BCD_EN is defined.
module f1_reaction_timer #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned CNT_WIDTH = 14,
  parameter int unsigned MAX_MS    = 9999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           lights,
  input  logic                 btn,
  output logic [CNT_WIDTH-1:0] result,
  output logic                 valid,
  output logic                 jump_start,
  output logic                 timeout,
  output logic                 busy
`ifdef F1_BCD_EN
  ,
  output logic [15:0]          result_bcd
`endif
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]        PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] MS_MAX     = CNT_WIDTH'(MAX_MS);

  typedef enum logic [2:0] {IDLE, ARMED, TIMING, DONE, FOUL} state_t;

  state_t               state;
  logic                 btn_q;
  logic                 seen_full;
  logic                 press;
  logic [PW-1:0]        presc;
  logic [CNT_WIDTH-1:0] ms_cnt;

  assign press = btn & ~btn_q;

`ifdef F1_BCD_EN
  logic [15:0] bcd_cnt;

  // Decimal increment with 9->0 ripple carry across the four digits.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      result     <= '0;
      valid      <= 1'b0;
      jump_start <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      presc      <= '0;
      ms_cnt     <= '0;
      seen_full  <= 1'b0;
      btn_q      <= 1'b1;
`ifdef F1_BCD_EN
      bcd_cnt    <= '0;
      result_bcd <= '0;
`endif
    end else begin
      btn_q <= btn;
      case (state)
        IDLE, DONE, FOUL: begin
          if (lights != '0) begin
            state      <= ARMED;
            busy       <= 1'b1;
            valid      <= 1'b0;
            jump_start <= 1'b0;
            timeout    <= 1'b0;
            result     <= '0;
            seen_full  <= (lights == 8'hFF);
`ifdef F1_BCD_EN
            result_bcd <= '0;
`endif
          end
        end
        ARMED: begin
          if (lights == 8'hFF) seen_full <= 1'b1;
          // A press beats lights-out arriving on the same edge.
          if (press) begin
            state      <= FOUL;
            busy       <= 1'b0;
            jump_start <= 1'b1;
            valid      <= 1'b1;
            result     <= '0;
`ifdef F1_BCD_EN
            result_bcd <= '0;
`endif
          end else if (lights == '0) begin
            if (seen_full) begin
              state  <= TIMING;
              presc  <= '0;
              ms_cnt <= '0;
`ifdef F1_BCD_EN
              bcd_cnt <= '0;
`endif
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        TIMING: begin
          if (press) begin
            state  <= DONE;
            busy   <= 1'b0;
            result <= ms_cnt;
            valid  <= 1'b1;
`ifdef F1_BCD_EN
            result_bcd <= bcd_cnt;
`endif
          end else if (ms_cnt == MS_MAX) begin
            state   <= DONE;
            busy    <= 1'b0;
            result  <= MS_MAX;
            timeout <= 1'b1;
            valid   <= 1'b1;
`ifdef F1_BCD_EN
            result_bcd <= bcd_cnt;
`endif
          end else if (presc == PRESC_LAST) begin
            presc  <= '0;
            ms_cnt <= ms_cnt + 1'b1;
`ifdef F1_BCD_EN
            bcd_cnt <= bcd_inc(bcd_cnt);
`endif
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
